sar_ctrl_param: RTL and testbench

//   Parametrised SAR (successive-approximation) controller for the on-chip ADC.

---
 rtl/sar_pkg.sv | 17 +
 rtl/sar_ctrl_param_if.sv | 29 ++
 rtl/sar_bit_engine.sv | 53 +++++
 rtl/sar_ctrl_param.sv | 156 +++++++++++++++
 tb/tb_sar_ctrl_param.sv | 205 ++++++++++++++++++++
 5 files changed

// File: rtl/sar_pkg.sv
// Shared definitions for the SAR ADC controller: FSM state encodings and
// legal parameter ranges.
package sar_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_SAMPLE  = 2'd1,
    ST_CONVERT = 2'd2,
    ST_DONE    = 2'd3
  } sar_state_e;

  localparam int unsigned SAR_WIDTH_MIN  = 2;
  localparam int unsigned SAR_WIDTH_MAX  = 16;
  localparam int unsigned SAR_SAMPLE_MIN = 1;
  localparam int unsigned SAR_SAMPLE_MAX = 255;

endpackage : sar_pkg

// File: rtl/sar_ctrl_param_if.sv
// Handshake/analog-side bundle between the SAR controller, the comparator/DAC
// and the result consumer.
interface sar_ctrl_param_if #(
  parameter int unsigned WIDTH = 8
);

  logic             start;
  logic             abort;
  logic             cont_mode;
  logic             cmp;
  logic             sample;
  logic [WIDTH-1:0] dac_code;
  logic             busy;
  logic [WIDTH-1:0] result;
  logic             result_valid;

  // controller side
  modport slave (
    input  start, abort, cont_mode, cmp,
    output sample, dac_code, busy, result, result_valid
  );

  // requester / analog-model side
  modport master (
    output start, abort, cont_mode, cmp,
    input  sample, dac_code, busy, result, result_valid
  );

endinterface : sar_ctrl_param_if

// File: rtl/sar_bit_engine.sv
// Successive-approximation datapath: one-hot trial mask and trial-code
// register, resolving one bit per step MSB-first.
module sar_bit_engine #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic             step,
  input  logic             clear,
  input  logic             cmp,
  output logic [WIDTH-1:0] dac_code,
  output logic             last_bit,
  output logic [WIDTH-1:0] resolved_c
);

  localparam logic [WIDTH-1:0] MSB_ONEHOT = {1'b1, {(WIDTH-1){1'b0}}};

  logic [WIDTH-1:0] code_q, code_d;
  logic [WIDTH-1:0] mask_q, mask_d;

  // Current trial code with the bit under test kept or dropped by cmp
  always_comb begin
    resolved_c = cmp ? code_q : (code_q & ~mask_q);
    code_d     = code_q;
    mask_d     = mask_q;
    if (clear) begin
      code_d = '0;
      mask_d = '0;
    end else if (load) begin
      code_d = MSB_ONEHOT;
      mask_d = MSB_ONEHOT;
    end else if (step) begin
      // shifting past bit 0 leaves mask empty, so no trial bit is added
      code_d = resolved_c | (mask_q >> 1);
      mask_d = mask_q >> 1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      code_q <= '0;
      mask_q <= '0;
    end else begin
      code_q <= code_d;
      mask_q <= mask_d;
    end
  end

  assign dac_code = code_q;
  assign last_bit = mask_q[0];

endmodule : sar_bit_engine

// File: rtl/sar_ctrl_param.sv
// SAR ADC controller: sample phase, WIDTH-cycle MSB-first conversion, registered
// result with one-cycle valid strobe, start/busy handshake, continuous mode, abort.
module sar_ctrl_param
  import sar_pkg::*;
#(
  parameter int unsigned WIDTH         = 8,
  parameter int unsigned SAMPLE_CYCLES = 2
) (
  input  logic             clk,
  input  logic             reset,
  sar_ctrl_param_if.slave  bus
);

  localparam int unsigned CNT_W = $clog2(SAMPLE_CYCLES + 1);

  if (WIDTH < SAR_WIDTH_MIN || WIDTH > SAR_WIDTH_MAX) begin : g_bad_width
    $error("sar_ctrl_param: WIDTH outside supported range");
  end
  if (SAMPLE_CYCLES < SAR_SAMPLE_MIN || SAMPLE_CYCLES > SAR_SAMPLE_MAX) begin : g_bad_sample
    $error("sar_ctrl_param: SAMPLE_CYCLES outside supported range");
  end

  sar_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             sample_q, sample_d;
  logic             busy_q, busy_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             result_valid_q, result_valid_d;

  logic             eng_load;
  logic             eng_step;
  logic             eng_clear;
  logic [WIDTH-1:0] eng_dac_code;
  logic             eng_last_bit;
  logic [WIDTH-1:0] eng_resolved_c;

  sar_bit_engine #(
    .WIDTH (WIDTH)
  ) u_bit_engine (
    .clk        (clk),
    .reset      (reset),
    .load       (eng_load),
    .step       (eng_step),
    .clear      (eng_clear),
    .cmp        (bus.cmp),
    .dac_code   (eng_dac_code),
    .last_bit   (eng_last_bit),
    .resolved_c (eng_resolved_c)
  );

  // Next-state and registered-output logic
  always_comb begin
    state_d        = state_q;
    cnt_d          = cnt_q;
    sample_d       = sample_q;
    busy_d         = busy_q;
    result_d       = result_q;
    result_valid_d = 1'b0;
    eng_load       = 1'b0;
    eng_step       = 1'b0;
    eng_clear      = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        sample_d = 1'b0;
        busy_d   = 1'b0;
        if (bus.start && !bus.abort) begin
          state_d   = ST_SAMPLE;
          sample_d  = 1'b1;
          busy_d    = 1'b1;
          cnt_d     = CNT_W'(SAMPLE_CYCLES);
          eng_clear = 1'b1;
        end
      end

      ST_SAMPLE: begin
        if (bus.abort) begin
          state_d   = ST_IDLE;
          sample_d  = 1'b0;
          busy_d    = 1'b0;
          eng_clear = 1'b1;
        end else if (cnt_q == CNT_W'(1)) begin
          state_d  = ST_CONVERT;
          sample_d = 1'b0;
          eng_load = 1'b1;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end

      ST_CONVERT: begin
        if (bus.abort) begin
          state_d   = ST_IDLE;
          sample_d  = 1'b0;
          busy_d    = 1'b0;
          eng_clear = 1'b1;
        end else begin
          eng_step = 1'b1;
          if (eng_last_bit) begin
            state_d        = ST_DONE;
            result_d       = eng_resolved_c;
            result_valid_d = 1'b1;
          end
        end
      end

      ST_DONE: begin
        // dac_code returns to zero on leaving DONE, into IDLE or a fresh sample
        eng_clear = 1'b1;
        if (!bus.abort && bus.cont_mode) begin
          state_d  = ST_SAMPLE;
          sample_d = 1'b1;
          cnt_d    = CNT_W'(SAMPLE_CYCLES);
        end else begin
          state_d  = ST_IDLE;
          sample_d = 1'b0;
          busy_d   = 1'b0;
        end
      end

      default: begin
        state_d   = ST_IDLE;
        cnt_d     = '0;
        sample_d  = 1'b0;
        busy_d    = 1'b0;
        result_d  = '0;
        eng_clear = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q        <= ST_IDLE;
      cnt_q          <= '0;
      sample_q       <= 1'b0;
      busy_q         <= 1'b0;
      result_q       <= '0;
      result_valid_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      sample_q       <= sample_d;
      busy_q         <= busy_d;
      result_q       <= result_d;
      result_valid_q <= result_valid_d;
    end
  end

  assign bus.sample       = sample_q;
  assign bus.dac_code     = eng_dac_code;
  assign bus.busy         = busy_q;
  assign bus.result       = result_q;
  assign bus.result_valid = result_valid_q;

endmodule : sar_ctrl_param

// File: tb/tb_sar_ctrl_param.sv
// Scoreboard bench for sar_ctrl_param (WIDTH=8, SAMPLE_CYCLES=2) with an ideal
// comparator model cmp = (vin >= dac_code).
module tb_sar_ctrl_param;

  localparam int unsigned WIDTH         = 8;
  localparam int unsigned SAMPLE_CYCLES = 2;
  localparam int          LAT           = 11;

  typedef struct {
    logic [7:0] res;
    int         cyc;
  } exp_t;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] vin;
  int         cyc = 0;
  int         n_cmp = 0;
  int         n_err = 0;
  exp_t       exp_q[$];
  logic [7:0] last_res;
  logic [7:0] trial [8];

  sar_ctrl_param_if #(.WIDTH(WIDTH)) bus ();

  sar_ctrl_param #(
    .WIDTH         (WIDTH),
    .SAMPLE_CYCLES (SAMPLE_CYCLES)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  assign bus.cmp = (vin >= bus.dac_code);

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_sample"}, 32'(bus.sample), 32'd0);
    chk({tag, "_dac"}, 32'(bus.dac_code), 32'd0);
    chk({tag, "_busy"}, 32'(bus.busy), 32'd0);
    chk({tag, "_result"}, 32'(bus.result), 32'd0);
    chk({tag, "_valid"}, 32'(bus.result_valid), 32'd0);
  endtask

  // Monitor: every valid pulse must match the next queued expectation
  always @(negedge clk) begin
    if (bus.result_valid === 1'b1) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL unexpected_valid: result %0h at cycle %0d, expected no pulse", bus.result, cyc);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("result", 32'(bus.result), 32'(e.res));
        chk("valid_cycle", 32'(cyc), 32'(e.cyc));
      end
    end
  end

  // One conversion from IDLE; start held for `hold` cycles, called at a negedge
  task automatic conv(input logic [7:0] v, input int hold, input bit check_trials);
    int busy_n;
    busy_n = 0;
    vin = v;
    bus.start = 1'b1;
    exp_q.push_back('{res: v, cyc: cyc + LAT});
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (i + 1 >= hold) bus.start = 1'b0;
      if (bus.busy === 1'b1) busy_n++;
      if (check_trials && i >= 2 && i <= 9)
        chk("dac_trial", 32'(bus.dac_code), 32'(trial[i-2]));
      if (i == 10) chk("dac_done_hold", 32'(bus.dac_code), 32'(v));
    end
    chk("busy_cycles", 32'(busy_n), 32'(LAT));
    chk("dac_idle", 32'(bus.dac_code), 32'd0);
    last_res = v;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation exceeded time limit at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    trial = '{8'h80, 8'hC0, 8'hA0, 8'hB0, 8'hA8, 8'hA4, 8'hA6, 8'hA5};
    reset         = 1'b1;
    vin           = 8'h00;
    bus.start     = 1'b0;
    bus.abort     = 1'b0;
    bus.cont_mode = 1'b0;
    last_res      = 8'h00;
    repeat (3) @(negedge clk);
    chk_reset_vals("reset");
    reset = 1'b0;
    @(negedge clk);

    // Basic conversion with DAC trial sequence
    conv(8'hA5, 1, 1'b1);
    repeat (2) @(negedge clk);

    // Extremes
    conv(8'h00, 1, 1'b0);
    conv(8'hFF, 1, 1'b0);
    @(negedge clk);

    // Continuous mode, cleared during the second conversion
    bus.cont_mode = 1'b1;
    vin = 8'h10;
    bus.start = 1'b1;
    exp_q.push_back('{res: 8'h10, cyc: cyc + LAT});
    exp_q.push_back('{res: 8'h3C, cyc: cyc + 2 * LAT});
    for (int i = 0; i < 24; i++) begin
      @(negedge clk);
      if (i == 0) bus.start = 1'b0;
      if (i == 10) vin = 8'h3C;
      if (i == 11) begin
        chk("cont_sample", 32'(bus.sample), 32'd1);
        chk("cont_busy", 32'(bus.busy), 32'd1);
      end
      if (i == 12) bus.cont_mode = 1'b0;
      if (i == 21) chk("cont_dac_done", 32'(bus.dac_code), 32'h3C);
      if (i == 22) chk("cont_stop_busy", 32'(bus.busy), 32'd0);
    end
    last_res = 8'h3C;

    // Start held through the whole conversion
    conv(8'h5A, 11, 1'b0);
    repeat (4) @(negedge clk);

    // Start and abort together in IDLE
    bus.start = 1'b1;
    bus.abort = 1'b1;
    @(negedge clk);
    chk("abort_idle_busy", 32'(bus.busy), 32'd0);
    chk("abort_idle_sample", 32'(bus.sample), 32'd0);
    bus.start = 1'b0;
    bus.abort = 1'b0;
    @(negedge clk);

    // Abort in the fourth CONVERT cycle
    vin = 8'hC3;
    bus.start = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (i == 0) bus.start = 1'b0;
      if (i == 5) bus.abort = 1'b1;
      if (i == 6) begin
        bus.abort = 1'b0;
        chk("abort_busy", 32'(bus.busy), 32'd0);
        chk("abort_dac", 32'(bus.dac_code), 32'd0);
        chk("abort_sample", 32'(bus.sample), 32'd0);
        chk("abort_result", 32'(bus.result), 32'(last_res));
      end
    end
    conv(8'h77, 1, 1'b0);

    // Reset mid-SAMPLE
    vin = 8'h42;
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    chk("pre_reset_sample", 32'(bus.sample), 32'd1);
    reset = 1'b1;
    @(negedge clk);
    chk_reset_vals("rst_sample");
    reset = 1'b0;
    @(negedge clk);

    // Reset in DONE
    vin = 8'h3C;
    bus.start = 1'b1;
    exp_q.push_back('{res: 8'h3C, cyc: cyc + LAT});
    for (int i = 0; i < 11; i++) begin
      @(negedge clk);
      if (i == 0) bus.start = 1'b0;
    end
    reset = 1'b1;
    @(negedge clk);
    chk_reset_vals("rst_done");
    reset = 1'b0;
    @(negedge clk);

    conv(8'h81, 1, 1'b0);
    repeat (3) @(negedge clk);
    chk("pending_results", 32'(exp_q.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule : tb_sar_ctrl_param
